// File: rtl/data_sync_pkg.sv
// -----------------------------------------------------------------------------
// data_sync_pkg
//   Shared definitions for the enable-based bus synchronizer (source launcher
//   and destination side).
//   - state_e : handshake state encoding used by the source launcher
//   - clog2   : ceiling log2 for sizing counters from parameters
// -----------------------------------------------------------------------------
package data_sync_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        REQ          = 2'd1,
        WAIT_ACK_LOW = 2'd2
    } state_e;

    // Ceiling log2; clog2(1) = 0, clog2(9) = 4.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/multi_flop_synchronizer.sv
// -----------------------------------------------------------------------------
// multi_flop_synchronizer
//   Plain flop chain for bringing an asynchronous level into the clk domain.
//   Ports:
//     clk    : destination clock
//     reset  : synchronous, active-high reset (clears every stage)
//     data_i : asynchronous input level(s)
//     data_o : synchronized level(s), STAGE_COUNT edges after data_i changes
// -----------------------------------------------------------------------------
module multi_flop_synchronizer #(
    parameter int STAGE_COUNT = 2,
    parameter int WIDTH       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [STAGE_COUNT];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its predecessor held before this edge; blocking
    // assignments here would collapse the chain into a single flop.
    // NOTE: the stages are individual flops, not a memory, so clearing them
    // on reset is cheap and keeps a stale ack from surviving a reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGE_COUNT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < STAGE_COUNT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[STAGE_COUNT-1];

endmodule

// File: rtl/data_sync_launcher.sv
// -----------------------------------------------------------------------------
// data_sync_launcher
//   Source-domain end of an enable-based bus synchronizer. Accepts a word from
//   local logic, drives it onto asynchronous_data with a level request
//   (asynchronous_data_valid), and runs a 4-phase req/ack handshake so the
//   destination always samples a stable bus.
//   Ports:
//     clk, reset              : source clock, synchronous active-high reset
//     src_data, src_valid     : word offered by local logic
//     src_ready               : word is accepted on this edge if src_valid
//     asynchronous_data       : registered word, frozen until the next accept
//     asynchronous_data_valid : registered request level
//     asynchronous_ack        : acknowledge from the destination (async)
//     transfer_done           : one-cycle pulse on normal handshake completion
//     timeout_err             : sticky, a request was abandoned for lack of ack
// -----------------------------------------------------------------------------
module data_sync_launcher
    import data_sync_pkg::*;
#(
    parameter int STAGE_COUNT    = 2,
    parameter int BUS_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] src_data,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic [BUS_WIDTH-1:0] asynchronous_data,
    output logic                 asynchronous_data_valid,
    input  logic                 asynchronous_ack,
    output logic                 transfer_done,
    output logic                 timeout_err
);

    localparam int CNT_W_RAW = clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Last count value before the request is abandoned; unused when disabled.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [BUS_WIDTH-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   aborted_q, aborted_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ack_sync;

    multi_flop_synchronizer #(
        .STAGE_COUNT (STAGE_COUNT),
        .WIDTH       (1)
    ) u_ack_sync (
        .clk    (clk),
        .reset  (reset),
        .data_i (asynchronous_ack),
        .data_o (ack_sync)
    );

    // A late or spurious ack seen in IDLE blocks new words until it clears,
    // so the next request never starts against a stale high ack.
    assign src_ready = (state_q == IDLE) && !ack_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
            cnt_q     <= cnt_d;
        end
    end

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        err_d     = err_q;
        aborted_d = aborted_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (src_valid && src_ready) begin
                    data_d    = src_data;
                    valid_d   = 1'b1;
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = REQ;
                end
            end

            REQ: begin
                // Ack is checked first so a simultaneous timeout hit is not
                // reported as an error.
                if (ack_sync) begin
                    valid_d = 1'b0;
                    state_d = WAIT_ACK_LOW;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    valid_d   = 1'b0;
                    err_d     = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = WAIT_ACK_LOW;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_ACK_LOW: begin
                // Data stays held here so the destination never sees the bus
                // move while its side of the handshake is still closing.
                if (!ack_sync) begin
                    state_d = IDLE;
                    done_d  = !aborted_q;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign asynchronous_data       = data_q;
    assign asynchronous_data_valid = valid_q;
    assign transfer_done           = done_q;
    assign timeout_err             = err_q;

endmodule

// File: tb/tb_data_sync_launcher.sv
// -----------------------------------------------------------------------------
// tb_data_sync_launcher
//   Directed bench for data_sync_launcher (STAGE_COUNT=2, BUS_WIDTH=4,
//   TIMEOUT_CYCLES=8). Accepted words are queued and compared when the DUT
//   raises its request; a small responder process plays the destination side.
// -----------------------------------------------------------------------------
module tb_data_sync_launcher;

    localparam int STAGES  = 2;
    localparam int BW      = 4;
    localparam int TIMEOUT = 8;

    logic          clk;
    logic          reset;
    logic [BW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic [BW-1:0] adata;
    logic          avalid;
    logic          ack;
    logic          done;
    logic          err;

    logic          man_ack;
    logic          resp_ack;
    logic          resp_en;
    int            resp_cnt;

    int            vectors;
    int            miscompares;
    int            done_cnt;
    logic          prev_valid;
    logic [BW-1:0] held_data;
    logic [BW-1:0] exp_q [$];

    assign ack = man_ack | resp_ack;

    data_sync_launcher #(
        .STAGE_COUNT    (STAGES),
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .src_data                (src_data),
        .src_valid               (src_valid),
        .src_ready               (src_ready),
        .asynchronous_data       (adata),
        .asynchronous_data_valid (avalid),
        .asynchronous_ack        (ack),
        .transfer_done           (done),
        .timeout_err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Destination model: raise ack 3 cycles after valid is seen high, drop it
    // 3 cycles after valid is seen low.
    initial begin : responder
        resp_ack = 1'b0;
        resp_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en !== 1'b1) begin
                resp_ack = 1'b0;
                resp_cnt = 0;
            end else if (!resp_ack) begin
                if (avalid === 1'b1) begin
                    resp_cnt = resp_cnt + 1;
                    if (resp_cnt == 3) begin
                        resp_ack = 1'b1;
                        resp_cnt = 0;
                    end
                end else begin
                    resp_cnt = 0;
                end
            end else begin
                if (avalid === 1'b0) begin
                    resp_cnt = resp_cnt + 1;
                    if (resp_cnt == 3) begin
                        resp_ack = 1'b0;
                        resp_cnt = 0;
                    end
                end else begin
                    resp_cnt = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: predicts acceptance from the pre-edge inputs, then samples
    // outputs 1 time unit after the edge and scores launches/stability.
    task automatic tick(output logic acc);
        logic [BW-1:0] word;
        acc  = (src_valid === 1'b1) && (src_ready === 1'b1) && (reset === 1'b0);
        word = src_data;
        @(posedge clk);
        if (acc) exp_q.push_back(word);
        #1;
        if (avalid === 1'b1 && prev_valid !== 1'b1) begin
            check("launch_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("launch_data", 32'(adata), 32'(exp_q.pop_front()));
            held_data = adata;
        end else if (avalid === 1'b1) begin
            check("data_stable", 32'(adata), 32'(held_data));
        end
        if (done === 1'b1) done_cnt++;
        prev_valid = avalid;
    endtask

    initial begin : stimulus
        logic acc;
        int   n;
        int   base;

        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        prev_valid  = 1'b0;
        held_data   = '0;
        man_ack     = 1'b0;
        resp_en     = 1'b0;
        reset       = 1'b1;
        src_valid   = 1'b1;
        src_data    = 4'hF;

        // Reset with a word offered: nothing accepted, outputs cleared.
        tick(acc);
        tick(acc);
        check("rst_data", 32'(adata), 0);
        check("rst_valid", 32'(avalid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        reset     = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        #1;
        check("rst_release_ready", 32'(src_ready), 1);
        tick(acc);
        check("rst_no_accept", 32'(avalid), 0);
        check("rst_queue_empty", 32'(exp_q.size()), 0);

        // Single transfer with precise handshake timing.
        base      = done_cnt;
        src_data  = 4'hA;
        src_valid = 1'b1;
        tick(acc);
        src_valid = 1'b0;
        src_data  = 4'h0;
        check("single_valid_up", 32'(avalid), 1);
        check("single_ready_busy", 32'(src_ready), 0);
        repeat (3) tick(acc);
        man_ack = 1'b1;
        n = 0;
        do begin
            tick(acc);
            n++;
        end while (avalid === 1'b1 && n < 10);
        check("ack_to_valid_fall_edges", n, STAGES + 1);
        repeat (3) tick(acc);
        check("wait_data_held", 32'(adata), 32'hA);
        check("wait_ready_low", 32'(src_ready), 0);
        man_ack = 1'b0;
        n = 0;
        do begin
            tick(acc);
            n++;
        end while (done !== 1'b1 && n < 10);
        check("ack_fall_to_done_edges", n, STAGES + 1);
        check("ready_with_done", 32'(src_ready), 1);
        check("idle_data_held", 32'(adata), 32'hA);
        tick(acc);
        check("done_one_cycle", 32'(done), 0);
        check("single_done_count", done_cnt - base, 1);

        // Sweep 0..15 with src_valid held and the responder looping.
        resp_en = 1'b1;
        base    = done_cnt;
        for (int w = 0; w < 16; w++) begin
            src_data  = BW'(w);
            src_valid = 1'b1;
            n = 0;
            do begin
                tick(acc);
                n++;
            end while (!acc && n < 60);
            check("sweep_accepted", 32'(acc), 1);
        end
        src_valid = 1'b0;
        n = 0;
        while ((done_cnt - base) < 16 && n < 100) begin
            tick(acc);
            n++;
        end
        check("sweep_done_count", done_cnt - base, 16);
        check("sweep_queue_empty", 32'(exp_q.size()), 0);
        check("sweep_no_err", 32'(err), 0);
        resp_en = 1'b0;
        repeat (4) tick(acc);

        // Timeout: ack held low, request abandoned after TIMEOUT cycles.
        base      = done_cnt;
        src_data  = 4'h5;
        src_valid = 1'b1;
        tick(acc);
        src_valid = 1'b0;
        check("to_accepted", 32'(acc), 1);
        n = 1;
        do begin
            tick(acc);
            if (avalid === 1'b1) n++;
        end while (avalid === 1'b1 && n < 30);
        check("to_valid_cycles", n, TIMEOUT);
        check("to_err_set", 32'(err), 1);
        tick(acc);
        check("to_exit_no_done", 32'(done), 0);
        check("to_ready_back", 32'(src_ready), 1);
        repeat (3) tick(acc);
        check("to_err_sticky", 32'(err), 1);
        check("to_no_done_count", done_cnt - base, 0);

        // Next word after a timeout goes through normally.
        resp_en   = 1'b1;
        src_data  = 4'h9;
        src_valid = 1'b1;
        tick(acc);
        src_valid = 1'b0;
        check("post_to_accepted", 32'(acc), 1);
        n = 0;
        while ((done_cnt - base) < 1 && n < 40) begin
            tick(acc);
            n++;
        end
        check("post_to_done", done_cnt - base, 1);
        check("post_to_err_sticky", 32'(err), 1);
        resp_en = 1'b0;
        repeat (4) tick(acc);

        // Reset while in REQ: immediate abort, no pulse, error cleared.
        base      = done_cnt;
        src_data  = 4'h3;
        src_valid = 1'b1;
        tick(acc);
        src_valid = 1'b0;
        check("rreq_accepted", 32'(acc), 1);
        tick(acc);
        tick(acc);
        reset = 1'b1;
        tick(acc);
        check("rreq_valid", 32'(avalid), 0);
        check("rreq_data", 32'(adata), 0);
        check("rreq_err", 32'(err), 0);
        check("rreq_done", 32'(done), 0);
        reset = 1'b0;
        tick(acc);
        check("rreq_idle_ready", 32'(src_ready), 1);
        check("rreq_no_done", done_cnt - base, 0);

        // Spurious ack in IDLE blocks acceptance for its synchronized span.
        man_ack = 1'b1;
        tick(acc);
        check("sp_ready_edge1", 32'(src_ready), 1);
        tick(acc);
        check("sp_ready_edge2", 32'(src_ready), 0);
        src_data  = 4'h7;
        src_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            check("sp_ready_blocked", 32'(src_ready), 0);
            check("sp_no_launch", 32'(avalid), 0);
        end
        man_ack = 1'b0;
        tick(acc);
        check("sp_ready_fall1", 32'(src_ready), 0);
        src_valid = 1'b0;
        tick(acc);
        check("sp_ready_fall2", 32'(src_ready), 1);
        check("sp_valid_low", 32'(avalid), 0);
        check("sp_queue_empty", 32'(exp_q.size()), 0);
        check("sp_no_done", done_cnt - base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
